// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-granular round-robin sharing of one UART transmitter between two byte streams.
// Optional stalled-lock release is compiled in by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TIMEOUT_W      = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req0_data_i,
  input  logic       req0_valid_i,
  input  logic       req0_last_i,
  output logic       req0_ready_o,
  input  logic [7:0] req1_data_i,
  input  logic       req1_valid_i,
  input  logic       req1_last_i,
  output logic       req1_ready_o,
  output logic [7:0] data_in_o,
  output logic       data_in_valid_o,
  input  logic       data_in_ready_i,
  output logic [1:0] grant_o,
  output logic       busy_o,
  output logic       timeout_event_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_e;

  if ((2 ** TIMEOUT_W) < TIMEOUT_CYCLES) begin : g_cfg_check
    $error("uart_tx_arbiter: TIMEOUT_W too narrow for TIMEOUT_CYCLES");
  end

  state_e     state_q;
  logic       last_owner_q;
  logic [7:0] data_q;
  logic       valid_q;
  logic [1:0] grant_q;

  logic       sel0;
  logic       sel1;
  logic       out_free;
  logic       acc0;
  logic       acc1;
  logic       acc_any;
  logic       acc_last_d;
  logic [7:0] acc_data_d;
  logic       stall_expire;

  // NOTE: in IDLE a requester's selection looks only at the *other* requester's valid,
  // so Ready never has a combinational path from its own Valid.
  always_comb begin
    sel0 = 1'b0;
    sel1 = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        sel0 = !req1_valid_i | last_owner_q;
        sel1 = !req0_valid_i | !last_owner_q;
      end
      ST_LOCK0: sel0 = 1'b1;
      ST_LOCK1: sel1 = 1'b1;
      default: begin
        sel0 = 1'b0;
        sel1 = 1'b0;
      end
    endcase
  end

  assign out_free     = !valid_q | data_in_ready_i;
  assign acc0         = sel0 & req0_valid_i & out_free;
  assign acc1         = sel1 & req1_valid_i & out_free;
  assign acc_any      = acc0 | acc1;
  assign acc_last_d   = acc1 ? req1_last_i : req0_last_i;
  assign acc_data_d   = acc1 ? req1_data_i : req0_data_i;

  assign req0_ready_o = sel0 & out_free;
  assign req1_ready_o = sel1 & out_free;

`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] idle_cnt_q;
  logic                 timeout_q;
  logic                 locked;
  logic                 owner_valid;

  assign locked       = (state_q != ST_IDLE);
  assign owner_valid  = (state_q == ST_LOCK1) ? req1_valid_i : req0_valid_i;
  assign stall_expire = locked & !owner_valid &
                        (idle_cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

  // An accept always coincides with owner_valid, so that term also covers "clear on accept".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= stall_expire;
      if (!locked || owner_valid || stall_expire) begin
        idle_cnt_q <= '0;
      end else begin
        idle_cnt_q <= idle_cnt_q + TIMEOUT_W'(1);
      end
    end
  end

  assign timeout_event_o = timeout_q;
`else
  assign stall_expire    = 1'b0;
  assign timeout_event_o = 1'b0;
`endif

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_owner_q <= 1'b1;
      data_q       <= 8'h00;
      valid_q      <= 1'b0;
      grant_q      <= 2'b00;
    end else begin
      if (acc_any) begin
        data_q  <= acc_data_d;
        valid_q <= 1'b1;
        grant_q <= {acc1, acc0};
      end else if (data_in_ready_i) begin
        valid_q <= 1'b0;
      end

      unique case (state_q)
        ST_IDLE: begin
          if (acc_any) begin
            if (acc_last_d) begin
              last_owner_q <= acc1;
            end else begin
              state_q <= acc1 ? ST_LOCK1 : ST_LOCK0;
            end
          end
        end
        ST_LOCK0, ST_LOCK1: begin
          if (acc_any && acc_last_d) begin
            state_q      <= ST_IDLE;
            last_owner_q <= acc1;
          end else if (stall_expire) begin
            state_q      <= ST_IDLE;
            last_owner_q <= (state_q == ST_LOCK1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign data_in_o       = data_q;
  assign data_in_valid_o = valid_q;
  assign grant_o         = grant_q;
  assign busy_o          = (state_q != ST_IDLE) | valid_q;

endmodule
